e_mdu: RTL and testbench

- Multiply/divide unit for the Execute stage of the 5-stage pipelined MIPS core.
- Consumes the two register-file read values (GRF rs/rt) after forwarding and the D/E pipeline register.
- Performs MULT/MULTU/DIV/DIVU with fixed multi-cycle latency, plus MTHI/MTLO, and holds the architectural HI/LO registers.
- Exposes a busy indication so the hazard unit stalls dependent MDU instructions in D.

---
 rtl/e_mdu_pkg.sv | 23 ++
 rtl/e_mdu_calc.sv | 58 +++++
 rtl/e_mdu.sv | 73 +++++++
 tb/tb_e_mdu.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/e_mdu_pkg.sv
// Shared definitions for the Execute-stage multiply/divide unit:
// operation encodings and default operation latencies.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6
  } mdu_op_e;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  localparam int CNT_W        = 8;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational 64-bit {HI,LO} result for MULT/MULTU/DIV/DIVU.
// Divide-by-zero returns the current HI/LO so the commit leaves them unchanged.
module mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               b_zero;
  logic               div_ovf;
  logic signed [31:0] div_bs;
  logic        [31:0] div_bu;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic        [31:0] q_u;
  logic        [31:0] r_u;

  assign a_sx   = $signed({{32{a[31]}}, a});
  assign b_sx   = $signed({{32{b[31]}}, b});
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Substitute a divisor of 1 in the special cases so the dividers never see
  // zero or the INT_MIN/-1 overflow; those results are muxed in below.
  assign b_zero  = (b == 32'd0);
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign div_bs  = (b_zero || div_ovf) ? 32'sd1 : $signed(b);
  assign div_bu  = b_zero ? 32'd1 : b;
  assign q_s     = $signed(a) / div_bs;
  assign r_s     = $signed(a) % div_bs;
  assign q_u     = a / div_bu;
  assign r_u     = a % div_bu;

  always_comb begin
    res = {hi, lo};
    case (op)
      MDU_MULT:  res = prod_s;
      MDU_MULTU: res = prod_u;
      MDU_DIV: begin
        if (b_zero)       res = {hi, lo};
        else if (div_ovf) res = {32'd0, 32'h8000_0000};
        else              res = {r_s, q_s};
      end
      MDU_DIVU:  res = b_zero ? {hi, lo} : {r_u, q_u};
      default:   res = {hi, lo};
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: holds HI/LO, runs MULT/DIV with a fixed
// latency and publishes the result only when the latency counter expires.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDUOp,
  input  logic        E_Start,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        E_Busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [31:0]      hi_s;
  logic [31:0]      lo_s;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic [63:0]      calc_res;
  logic             accept;

  mdu_calc u_calc (
    .a   (E_A),
    .b   (E_B),
    .op  (E_MDUOp),
    .hi  (hi),
    .lo  (lo),
    .res (calc_res)
  );

  assign accept = E_Start && is_muldiv(E_MDUOp) && !busy;

  // The result is computed once at acceptance and parked in the shadow
  // registers; HI/LO only change on the counter's 1->0 edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= 32'd0;
      lo   <= 32'd0;
      hi_s <= 32'd0;
      lo_s <= 32'd0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        hi   <= hi_s;
        lo   <= lo_s;
        busy <= 1'b0;
      end
    end else if (accept) begin
      {hi_s, lo_s} <= calc_res;
      cnt          <= (E_MDUOp == MDU_MULT || E_MDUOp == MDU_MULTU) ?
                      CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
      busy         <= 1'b1;
    end else if (E_MDUOp == MDU_MTHI) begin
      hi <= E_A;
    end else if (E_MDUOp == MDU_MTLO) begin
      lo <= E_A;
    end
  end

  assign E_Busy = busy;
  assign E_HI   = hi;
  assign E_LO   = lo;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: latency, arithmetic results, MT* writes,
// ignored requests while busy and reset during an operation.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  E_MDUOp;
  logic        E_Start;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_Busy;
  logic [31:0] E_HI;
  logic [31:0] E_LO;

  int n_cmp;
  int n_bad;

  e_mdu dut (
    .clk     (clk),
    .reset   (reset),
    .E_MDUOp (E_MDUOp),
    .E_Start (E_Start),
    .E_A     (E_A),
    .E_B     (E_B),
    .E_Busy  (E_Busy),
    .E_HI    (E_HI),
    .E_LO    (E_LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    E_MDUOp = MDU_NONE;
    E_Start = 1'b0;
    E_A     = 32'd0;
    E_B     = 32'd0;
  endtask

  // Issue one multi-cycle op, count busy cycles, check HI/LO before and after.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int n;
    old_hi = E_HI;
    old_lo = E_LO;
    E_MDUOp = op;
    E_Start = 1'b1;
    E_A     = a;
    E_B     = b;
    step();
    idle();
    chk({tag, "_hi_early"}, E_HI, old_hi);
    chk({tag, "_lo_early"}, E_LO, old_lo);
    n = 0;
    while (E_Busy && n < 40) begin
      n++;
      step();
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(lat));
    chk({tag, "_hi"}, E_HI, exp_hi);
    chk({tag, "_lo"}, E_LO, exp_lo);
  endtask

  initial begin
    int n;
    int late;
    n_cmp = 0;
    n_bad = 0;
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_busy", 32'(E_Busy), 32'd0);
    chk("rst_hi", E_HI, 32'd0);
    chk("rst_lo", E_LO, 32'd0);

    run_op("mult",    MDU_MULT,  32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu",   MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div",     MDU_DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",    MDU_DIVU,  32'd7,         32'd2,         10, 32'd1,         32'd3);
    run_op("div_ovf", MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000);

    E_MDUOp = MDU_MTHI;
    E_A     = 32'h1234;
    step();
    idle();
    chk("mthi_hi", E_HI, 32'h1234);
    chk("mthi_lo_kept", E_LO, 32'h8000_0000);
    E_MDUOp = MDU_MTLO;
    E_A     = 32'h5678;
    step();
    idle();
    chk("mtlo_lo", E_LO, 32'h5678);
    chk("mtlo_hi_kept", E_HI, 32'h1234);

    run_op("divu_z", MDU_DIVU, 32'd99, 32'd0, 10, 32'h1234, 32'h5678);

    // DIV -7/2 with a MULT start at busy cycle 3 and MTLO at busy cycle 4.
    E_MDUOp = MDU_DIV;
    E_Start = 1'b1;
    E_A     = 32'hFFFF_FFF9;
    E_B     = 32'd2;
    step();
    idle();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (E_Busy) n++;
      if (i == 2) begin
        E_MDUOp = MDU_MULT;
        E_Start = 1'b1;
        E_A     = 32'd5;
        E_B     = 32'd5;
      end else if (i == 3) begin
        E_MDUOp = MDU_MTLO;
        E_A     = 32'hDEAD;
      end else begin
        idle();
      end
      if (i == 8) chk("intf_hi_early", E_HI, 32'h1234);
      step();
    end
    chk("intf_busy_cycles", 32'(n), 32'd10);
    chk("intf_hi", E_HI, 32'hFFFF_FFFF);
    chk("intf_lo", E_LO, 32'hFFFF_FFFD);

    // Reset in the middle of a MULT discards it.
    E_MDUOp = MDU_MULT;
    E_Start = 1'b1;
    E_A     = 32'd3;
    E_B     = 32'd4;
    step();
    idle();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_busy", 32'(E_Busy), 32'd0);
    chk("mrst_hi", E_HI, 32'd0);
    chk("mrst_lo", E_LO, 32'd0);
    late = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (E_Busy || E_HI != 32'd0 || E_LO != 32'd0) late++;
    end
    chk("mrst_no_late_commit", 32'(late), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
